// File: rtl/frame_info_pack.sv
// -----------------------------------------------------------------------------
// frame_info_pack
//   Packs per-frame information into fixed-size 64-bit word segments for a
//   GigE Vision style command stream. Two segment types exist: an "info"
//   segment and a "statis" segment. Their field inputs are captured on the
//   cycle the start request is accepted. Each segment is then streamed word
//   by word, and a word moves whenever the downstream is ready.
//
// Ports
//   clk, reset           : clock, asynchronous active-high reset
//   i_info_start         : pulse requesting an info segment
//   i_statis_start       : pulse requesting a statis segment
//   i_ready              : downstream accepts a word this cycle
//   iv_*                 : field values, captured when a request is accepted
//   o_info_flag          : info segment active
//   o_statis_flag        : statis segment active
//   ov_dval              : word valid (per 4-byte lane)
//   ov_cmd_data          : current segment word
//   o_busy               : segment active, in gap, or request pending
//   o_overflow           : one-cycle pulse when a request was dropped
// -----------------------------------------------------------------------------
module frame_info_pack #(
    parameter int INFO_SIZE    = 256,
    parameter int STATIS_SIZE  = 256,
    parameter int SHORT_REG_WD = 16,
    parameter int REG_WD       = 32,
    parameter int LONG_REG_WD  = 64,
    parameter int GEV_DE_WD    = 2,
    parameter int GEV_DATA_WD  = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_info_start,
    input  logic                    i_statis_start,
    input  logic                    i_ready,
    input  logic [LONG_REG_WD-1:0]  iv_block_id,
    input  logic [LONG_REG_WD-1:0]  iv_timestamp,
    input  logic [LONG_REG_WD-1:0]  iv_frame_interval,
    input  logic [REG_WD-1:0]       iv_pixel_format,
    input  logic [REG_WD-1:0]       iv_image_size,
    input  logic [REG_WD-1:0]       iv_payload_size,
    input  logic [SHORT_REG_WD-1:0] iv_width,
    input  logic [SHORT_REG_WD-1:0] iv_height,
    input  logic [SHORT_REG_WD-1:0] iv_offset_x,
    input  logic [SHORT_REG_WD-1:0] iv_offset_y,
    input  logic [SHORT_REG_WD-1:0] iv_chunk_info,
    input  logic [SHORT_REG_WD-1:0] iv_status_info,
    input  logic [REG_WD-1:0]       iv_expect_payload_size,
    input  logic [REG_WD-1:0]       iv_valid_payload_size,
    input  logic [SHORT_REG_WD-1:0] iv_status_statis,
    output logic                    o_info_flag,
    output logic                    o_statis_flag,
    output logic [GEV_DE_WD-1:0]    ov_dval,
    output logic [GEV_DATA_WD-1:0]  ov_cmd_data,
    output logic                    o_busy,
    output logic                    o_overflow
);

    localparam int INFO_WORDS   = INFO_SIZE / 8;
    localparam int STATIS_WORDS = STATIS_SIZE / 8;
    localparam int MAX_WORDS    = (INFO_WORDS > STATIS_WORDS) ? INFO_WORDS : STATIS_WORDS;
    localparam int CNT_WD       = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INFO   = 2'd1,
        ST_STATIS = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    state_t              state_d, state_q;
    logic [CNT_WD-1:0]   cnt_d, cnt_q;
    logic                info_pend_d, info_pend_q;
    logic                statis_pend_d, statis_pend_q;
    logic                overflow_d, overflow_q;

    // Snapshot registers
    logic [LONG_REG_WD-1:0]  block_id_d, block_id_q;
    logic [LONG_REG_WD-1:0]  timestamp_d, timestamp_q;
    logic [LONG_REG_WD-1:0]  frame_interval_d, frame_interval_q;
    logic [REG_WD-1:0]       pixel_format_d, pixel_format_q;
    logic [REG_WD-1:0]       image_size_d, image_size_q;
    logic [REG_WD-1:0]       payload_size_d, payload_size_q;
    logic [SHORT_REG_WD-1:0] width_d, width_q;
    logic [SHORT_REG_WD-1:0] height_d, height_q;
    logic [SHORT_REG_WD-1:0] offset_x_d, offset_x_q;
    logic [SHORT_REG_WD-1:0] offset_y_d, offset_y_q;
    logic [SHORT_REG_WD-1:0] chunk_info_d, chunk_info_q;
    logic [SHORT_REG_WD-1:0] status_info_d, status_info_q;
    logic [REG_WD-1:0]       expect_size_d, expect_size_q;
    logic [REG_WD-1:0]       valid_size_d, valid_size_q;
    logic [SHORT_REG_WD-1:0] status_statis_d, status_statis_q;

    logic              info_accept;
    logic              statis_accept;
    logic [CNT_WD-1:0] last_word;
    logic              seg_active;
    logic [GEV_DATA_WD-1:0] cmd_data;

    // Request acceptance: a request of a type that is already pending or
    // being sent is dropped so the snapshot it would overwrite stays intact.
    always_comb begin
        info_accept   = i_info_start && !info_pend_q && (state_q != ST_INFO);
        statis_accept = i_statis_start && !statis_pend_q && (state_q != ST_STATIS);
        overflow_d    = (i_info_start && !info_accept) || (i_statis_start && !statis_accept);
    end

    // Snapshot capture on accepted requests
    always_comb begin
        block_id_d       = block_id_q;
        timestamp_d      = timestamp_q;
        frame_interval_d = frame_interval_q;
        pixel_format_d   = pixel_format_q;
        image_size_d     = image_size_q;
        payload_size_d   = payload_size_q;
        width_d          = width_q;
        height_d         = height_q;
        offset_x_d       = offset_x_q;
        offset_y_d       = offset_y_q;
        chunk_info_d     = chunk_info_q;
        status_info_d    = status_info_q;
        expect_size_d    = expect_size_q;
        valid_size_d     = valid_size_q;
        status_statis_d  = status_statis_q;
        if (info_accept) begin
            block_id_d       = iv_block_id;
            timestamp_d      = iv_timestamp;
            frame_interval_d = iv_frame_interval;
            pixel_format_d   = iv_pixel_format;
            image_size_d     = iv_image_size;
            payload_size_d   = iv_payload_size;
            width_d          = iv_width;
            height_d         = iv_height;
            offset_x_d       = iv_offset_x;
            offset_y_d       = iv_offset_y;
            chunk_info_d     = iv_chunk_info;
            status_info_d    = iv_status_info;
        end else begin
            block_id_d       = block_id_q;
        end
        if (statis_accept) begin
            expect_size_d    = iv_expect_payload_size;
            valid_size_d     = iv_valid_payload_size;
            status_statis_d  = iv_status_statis;
        end else begin
            expect_size_d    = expect_size_q;
        end
    end

    // Next-state, word counter and pending-latch logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        info_pend_d   = info_pend_q | info_accept;
        statis_pend_d = statis_pend_q | statis_accept;
        last_word     = (state_q == ST_INFO) ? CNT_WD'(INFO_WORDS - 1) : CNT_WD'(STATIS_WORDS - 1);
        case (state_q)
            // GAP dispatches like IDLE: the GAP cycle itself already provides
            // the flag-low separation, so a queued segment starts right after.
            // A same-cycle request is included so the flag rises one cycle
            // after the start pulse.
            ST_IDLE, ST_GAP: begin
                cnt_d = {CNT_WD{1'b0}};
                if (info_pend_d) begin
                    state_d     = ST_INFO;
                    info_pend_d = 1'b0;
                end else if (statis_pend_d) begin
                    state_d       = ST_STATIS;
                    statis_pend_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INFO, ST_STATIS: begin
                if (i_ready) begin
                    if (cnt_q == last_word) begin
                        state_d = ST_GAP;
                        cnt_d   = {CNT_WD{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_WD'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_WD{1'b0}};
            end
        endcase
    end

    // Segment word selection from the snapshot
    always_comb begin
        cmd_data = {GEV_DATA_WD{1'b0}};
        if (state_q == ST_INFO) begin
            case (cnt_q)
                CNT_WD'(0): cmd_data = block_id_q;
                CNT_WD'(1): cmd_data = timestamp_q;
                CNT_WD'(2): cmd_data = {16'h0000, width_q, pixel_format_q};
                CNT_WD'(3): cmd_data = {16'h0000, offset_x_q, 16'h0000, height_q};
                CNT_WD'(4): cmd_data = {16'h0000, chunk_info_q, 16'h0000, offset_y_q};
                CNT_WD'(5): cmd_data = {payload_size_q, image_size_q};
                CNT_WD'(6): cmd_data = frame_interval_q;
                CNT_WD'(7): cmd_data = {48'h0000_0000_0000, status_info_q};
                default:    cmd_data = {GEV_DATA_WD{1'b0}};
            endcase
        end else if (state_q == ST_STATIS) begin
            case (cnt_q)
                CNT_WD'(0): cmd_data = {valid_size_q, expect_size_q};
                CNT_WD'(1): cmd_data = {48'h0000_0000_0000, status_statis_q};
                default:    cmd_data = {GEV_DATA_WD{1'b0}};
            endcase
        end else begin
            cmd_data = {GEV_DATA_WD{1'b0}};
        end
    end

    // State, counter, latches and snapshots
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            cnt_q            <= {CNT_WD{1'b0}};
            info_pend_q      <= 1'b0;
            statis_pend_q    <= 1'b0;
            overflow_q       <= 1'b0;
            block_id_q       <= {LONG_REG_WD{1'b0}};
            timestamp_q      <= {LONG_REG_WD{1'b0}};
            frame_interval_q <= {LONG_REG_WD{1'b0}};
            pixel_format_q   <= {REG_WD{1'b0}};
            image_size_q     <= {REG_WD{1'b0}};
            payload_size_q   <= {REG_WD{1'b0}};
            width_q          <= {SHORT_REG_WD{1'b0}};
            height_q         <= {SHORT_REG_WD{1'b0}};
            offset_x_q       <= {SHORT_REG_WD{1'b0}};
            offset_y_q       <= {SHORT_REG_WD{1'b0}};
            chunk_info_q     <= {SHORT_REG_WD{1'b0}};
            status_info_q    <= {SHORT_REG_WD{1'b0}};
            expect_size_q    <= {REG_WD{1'b0}};
            valid_size_q     <= {REG_WD{1'b0}};
            status_statis_q  <= {SHORT_REG_WD{1'b0}};
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            info_pend_q      <= info_pend_d;
            statis_pend_q    <= statis_pend_d;
            overflow_q       <= overflow_d;
            block_id_q       <= block_id_d;
            timestamp_q      <= timestamp_d;
            frame_interval_q <= frame_interval_d;
            pixel_format_q   <= pixel_format_d;
            image_size_q     <= image_size_d;
            payload_size_q   <= payload_size_d;
            width_q          <= width_d;
            height_q         <= height_d;
            offset_x_q       <= offset_x_d;
            offset_y_q       <= offset_y_d;
            chunk_info_q     <= chunk_info_d;
            status_info_q    <= status_info_d;
            expect_size_q    <= expect_size_d;
            valid_size_q     <= valid_size_d;
            status_statis_q  <= status_statis_d;
        end
    end

    // Outputs: flags follow the state register; dval mirrors i_ready only
    // inside a segment so a transfer is exactly "flag and ready".
    always_comb begin
        seg_active    = (state_q == ST_INFO) || (state_q == ST_STATIS);
        o_info_flag   = (state_q == ST_INFO);
        o_statis_flag = (state_q == ST_STATIS);
        ov_dval       = seg_active ? {GEV_DE_WD{i_ready}} : {GEV_DE_WD{1'b0}};
        ov_cmd_data   = cmd_data;
        o_busy        = (state_q != ST_IDLE) || info_pend_q || statis_pend_q;
        o_overflow    = overflow_q;
    end

endmodule

// File: tb/tb_frame_info_pack.sv
// -----------------------------------------------------------------------------
// tb_frame_info_pack
//   Directed self-checking bench for frame_info_pack. Inputs are driven on the
//   falling edge, outputs are sampled 1 ns later, the DUT acts on rising edges.
// -----------------------------------------------------------------------------
module tb_frame_info_pack;

    logic        clk;
    logic        reset;
    logic        i_info_start, i_statis_start, i_ready;
    logic [63:0] iv_block_id, iv_timestamp, iv_frame_interval;
    logic [31:0] iv_pixel_format, iv_image_size, iv_payload_size;
    logic [15:0] iv_width, iv_height, iv_offset_x, iv_offset_y, iv_chunk_info, iv_status_info;
    logic [31:0] iv_expect_payload_size, iv_valid_payload_size;
    logic [15:0] iv_status_statis;
    logic        o_info_flag, o_statis_flag;
    logic [1:0]  ov_dval;
    logic [63:0] ov_cmd_data;
    logic        o_busy, o_overflow;

    int errors = 0;
    int checks = 0;
    int ovf_cnt = 0;
    logic [63:0] seg_words [0:63];

    frame_info_pack dut (
        .clk(clk), .reset(reset),
        .i_info_start(i_info_start), .i_statis_start(i_statis_start), .i_ready(i_ready),
        .iv_block_id(iv_block_id), .iv_timestamp(iv_timestamp), .iv_frame_interval(iv_frame_interval),
        .iv_pixel_format(iv_pixel_format), .iv_image_size(iv_image_size), .iv_payload_size(iv_payload_size),
        .iv_width(iv_width), .iv_height(iv_height), .iv_offset_x(iv_offset_x), .iv_offset_y(iv_offset_y),
        .iv_chunk_info(iv_chunk_info), .iv_status_info(iv_status_info),
        .iv_expect_payload_size(iv_expect_payload_size), .iv_valid_payload_size(iv_valid_payload_size),
        .iv_status_statis(iv_status_statis),
        .o_info_flag(o_info_flag), .o_statis_flag(o_statis_flag), .ov_dval(ov_dval),
        .ov_cmd_data(ov_cmd_data), .o_busy(o_busy), .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count overflow pulses, sampled mid-cycle
    always @(negedge clk) begin
        #1;
        if (o_overflow === 1'b1) ovf_cnt = ovf_cnt + 1;
    end

    // Fixed info field values used by every info scenario
    localparam logic [63:0] TS  = 64'h0000_0001_0000_0002;
    localparam logic [63:0] FI  = 64'h0000_0000_0001_E848;
    localparam logic [31:0] PF  = 32'h0108_0001;
    localparam logic [31:0] IMG = 32'h0014_0000;
    localparam logic [31:0] PAY = 32'h0014_0100;

    function automatic logic [63:0] exp_info_word(input int k, input logic [63:0] blk,
                                                  input logic [15:0] w, input logic [15:0] h);
        case (k)
            0: return blk;
            1: return TS;
            2: return {16'h0000, w, PF};
            3: return {16'h0000, 16'h0010, 16'h0000, h};
            4: return {16'h0000, 16'h0001, 16'h0000, 16'h0020};
            5: return {PAY, IMG};
            6: return FI;
            7: return 64'h0000_0000_0000_0005;
            default: return 64'h0;
        endcase
    endfunction

    task automatic set_info(input logic [63:0] blk, input logic [15:0] w, input logic [15:0] h);
        iv_block_id = blk; iv_timestamp = TS; iv_frame_interval = FI;
        iv_pixel_format = PF; iv_image_size = IMG; iv_payload_size = PAY;
        iv_width = w; iv_height = h; iv_offset_x = 16'h0010; iv_offset_y = 16'h0020;
        iv_chunk_info = 16'h0001; iv_status_info = 16'h0005;
    endtask

    // Overwrite every field input so a snapshot leak would show in the words
    task automatic scramble;
        iv_block_id = 64'hDEAD_BEEF_DEAD_BEEF; iv_timestamp = 64'hFFFF_FFFF_FFFF_FFFF;
        iv_frame_interval = 64'hAAAA_AAAA_AAAA_AAAA; iv_pixel_format = 32'hFFFF_FFFF;
        iv_image_size = 32'hEEEE_EEEE; iv_payload_size = 32'hDDDD_DDDD;
        iv_width = 16'hFFFF; iv_height = 16'hFFFF; iv_offset_x = 16'hFFFF; iv_offset_y = 16'hFFFF;
        iv_chunk_info = 16'hFFFF; iv_status_info = 16'hFFFF;
        iv_expect_payload_size = 32'hCCCC_CCCC; iv_valid_payload_size = 32'hBBBB_BBBB;
        iv_status_statis = 16'hFFFF;
    endtask

    // Pulse one or both starts for one clock edge, then scramble the fields
    task automatic pulse_start(input logic info, input logic statis);
        @(negedge clk);
        i_info_start = info; i_statis_start = statis;
        @(posedge clk);
        #1;
        i_info_start = 1'b0; i_statis_start = 1'b0;
        scramble();
    endtask

    // Observe one segment: low cycles before the flag, flag-high cycles,
    // transfers (stored in seg_words), stall-stability and dval violations.
    task automatic run_seg(input logic is_info, input logic toggle, input int pulse_at,
                           output int lows, output int highs, output int xfers,
                           output int unstable, output int dval_bad, output int timed_out);
        logic        flag;
        logic        stalled;
        logic        pulsed;
        logic [63:0] prev;
        lows = 0; highs = 0; xfers = 0; unstable = 0; dval_bad = 0; timed_out = 1;
        stalled = 1'b0; pulsed = 1'b0; prev = 64'h0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            i_info_start = 1'b0; i_statis_start = 1'b0;
            if (highs == pulse_at && !pulsed) begin
                i_info_start = 1'b1; iv_block_id = 64'h99; iv_width = 16'h0777;
                pulsed = 1'b1;
            end
            i_ready = toggle ? ((highs % 2) == 0) : 1'b1;
            #1;
            flag = is_info ? o_info_flag : o_statis_flag;
            if (flag === 1'b1) begin
                if (ov_dval !== {2{i_ready}}) dval_bad++;
                if (stalled && ov_cmd_data !== prev) unstable++;
                highs++;
                if (ov_dval[0] === 1'b1) begin
                    if (xfers < 64) seg_words[xfers] = ov_cmd_data;
                    xfers++;
                end
                stalled = (ov_dval[0] !== 1'b1);
                prev = ov_cmd_data;
            end else if (highs > 0) begin
                if (ov_dval !== 2'b00 || o_info_flag !== 1'b0 || o_statis_flag !== 1'b0) dval_bad++;
                timed_out = 0;
                break;
            end else begin
                lows++;
            end
        end
        i_ready = 1'b1;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (o_info_flag !== 1'b0 || o_statis_flag !== 1'b0) begin errors++;
            $display("FAIL reset_flags: got %b%b expected 00", o_info_flag, o_statis_flag); end
        checks++; if (ov_dval !== 2'b00) begin errors++;
            $display("FAIL reset_dval: got %b expected 00", ov_dval); end
        checks++; if (ov_cmd_data !== 64'h0) begin errors++;
            $display("FAIL reset_data: got %h expected 0", ov_cmd_data); end
        checks++; if (o_busy !== 1'b0 || o_overflow !== 1'b0) begin errors++;
            $display("FAIL reset_busy_ovf: got %b%b expected 00", o_busy, o_overflow); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_info;
        int lows, highs, xfers, unst, dbad, tmo, nz;
        set_info(64'h11, 16'h0500, 16'h0400);
        pulse_start(1'b1, 1'b0);
        run_seg(1'b1, 1'b0, -1, lows, highs, xfers, unst, dbad, tmo);
        checks++; if (tmo != 0) begin errors++; $display("FAIL info_timeout: got %0d expected 0", tmo); end
        checks++; if (lows != 0) begin errors++; $display("FAIL info_latency: got %0d low cycles expected 0", lows); end
        checks++; if (highs != 32) begin errors++; $display("FAIL info_flag_len: got %0d expected 32", highs); end
        checks++; if (xfers != 32) begin errors++; $display("FAIL info_xfers: got %0d expected 32", xfers); end
        checks++; if (dbad != 0) begin errors++; $display("FAIL info_dval: got %0d bad expected 0", dbad); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL info_busy_gap: got %b expected 1", o_busy); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (seg_words[k] !== exp_info_word(k, 64'h11, 16'h0500, 16'h0400)) begin errors++;
                $display("FAIL info_word%0d: got %h expected %h", k, seg_words[k],
                         exp_info_word(k, 64'h11, 16'h0500, 16'h0400)); end
        end
        nz = 0;
        for (int k = 8; k < 32; k++) if (seg_words[k] !== 64'h0) nz++;
        checks++; if (nz != 0) begin errors++; $display("FAIL info_zero_words: got %0d nonzero expected 0", nz); end
        @(negedge clk); #1;
        checks++; if (o_busy !== 1'b0 || ov_cmd_data !== 64'h0) begin errors++;
            $display("FAIL info_idle_after: got busy=%b data=%h expected 0/0", o_busy, ov_cmd_data); end
    endtask

    task automatic test_statis;
        int lows, highs, xfers, unst, dbad, tmo, nz;
        iv_expect_payload_size = 32'h1000; iv_valid_payload_size = 32'h0F00; iv_status_statis = 16'h3;
        pulse_start(1'b0, 1'b1);
        run_seg(1'b0, 1'b0, -1, lows, highs, xfers, unst, dbad, tmo);
        checks++; if (tmo != 0 || lows != 0 || highs != 32 || xfers != 32) begin errors++;
            $display("FAIL statis_shape: got tmo=%0d lows=%0d highs=%0d xfers=%0d expected 0/0/32/32", tmo, lows, highs, xfers); end
        checks++; if (seg_words[0] !== 64'h00000F00_00001000) begin errors++;
            $display("FAIL statis_word0: got %h expected 00000f0000001000", seg_words[0]); end
        checks++; if (seg_words[1] !== 64'h3) begin errors++;
            $display("FAIL statis_word1: got %h expected 3", seg_words[1]); end
        nz = 0;
        for (int k = 2; k < 32; k++) if (seg_words[k] !== 64'h0) nz++;
        checks++; if (nz != 0) begin errors++; $display("FAIL statis_zero_words: got %0d nonzero expected 0", nz); end
        @(negedge clk);
    endtask

    task automatic test_ready_toggle;
        int lows, highs, xfers, unst, dbad, tmo;
        set_info(64'h22, 16'h0280, 16'h01E0);
        pulse_start(1'b1, 1'b0);
        run_seg(1'b1, 1'b1, -1, lows, highs, xfers, unst, dbad, tmo);
        checks++; if (tmo != 0 || highs != 63) begin errors++;
            $display("FAIL toggle_flag_len: got %0d (tmo=%0d) expected 63", highs, tmo); end
        checks++; if (xfers != 32) begin errors++; $display("FAIL toggle_xfers: got %0d expected 32", xfers); end
        checks++; if (unst != 0) begin errors++; $display("FAIL toggle_stable: got %0d changes expected 0", unst); end
        checks++; if (dbad != 0) begin errors++; $display("FAIL toggle_dval: got %0d bad expected 0", dbad); end
        checks++; if (seg_words[2] !== exp_info_word(2, 64'h22, 16'h0280, 16'h01E0)) begin errors++;
            $display("FAIL toggle_word2: got %h expected %h", seg_words[2], exp_info_word(2, 64'h22, 16'h0280, 16'h01E0)); end
        checks++; if (seg_words[3] !== exp_info_word(3, 64'h22, 16'h0280, 16'h01E0)) begin errors++;
            $display("FAIL toggle_word3: got %h expected %h", seg_words[3], exp_info_word(3, 64'h22, 16'h0280, 16'h01E0)); end
        @(negedge clk);
    endtask

    task automatic test_simultaneous;
        int l1, h1, x1, u1, d1, t1, l2, h2, x2, u2, d2, t2, ovf0;
        logic [63:0] info_w0;
        set_info(64'h33, 16'h0100, 16'h0080);
        iv_expect_payload_size = 32'h2000; iv_valid_payload_size = 32'h1F00; iv_status_statis = 16'h7;
        ovf0 = ovf_cnt;
        pulse_start(1'b1, 1'b1);
        run_seg(1'b1, 1'b0, -1, l1, h1, x1, u1, d1, t1);
        info_w0 = seg_words[0];
        run_seg(1'b0, 1'b0, -1, l2, h2, x2, u2, d2, t2);
        checks++; if (t1 != 0 || l1 != 0 || x1 != 32) begin errors++;
            $display("FAIL simul_info: got tmo=%0d lows=%0d xfers=%0d expected 0/0/32", t1, l1, x1); end
        checks++; if (info_w0 !== 64'h33) begin errors++; $display("FAIL simul_info_w0: got %h expected 33", info_w0); end
        checks++; if (l2 != 0) begin errors++;
            $display("FAIL simul_gap: got %0d flags-low cycles expected 1", l2 + 1); end
        checks++; if (t2 != 0 || x2 != 32) begin errors++;
            $display("FAIL simul_statis: got tmo=%0d xfers=%0d expected 0/32", t2, x2); end
        checks++; if (seg_words[0] !== 64'h00001F00_00002000) begin errors++;
            $display("FAIL simul_statis_w0: got %h expected 00001f0000002000", seg_words[0]); end
        checks++; if (ovf_cnt != ovf0) begin errors++;
            $display("FAIL simul_overflow: got %0d pulses expected 0", ovf_cnt - ovf0); end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        int lows, highs, xfers, unst, dbad, tmo, ovf0;
        set_info(64'h44, 16'h0600, 16'h0300);
        ovf0 = ovf_cnt;
        pulse_start(1'b1, 1'b0);
        run_seg(1'b1, 1'b0, 1, lows, highs, xfers, unst, dbad, tmo);
        checks++; if (ovf_cnt - ovf0 != 1) begin errors++;
            $display("FAIL ovf_pulses: got %0d expected 1", ovf_cnt - ovf0); end
        checks++; if (tmo != 0 || xfers != 32) begin errors++;
            $display("FAIL ovf_xfers: got %0d (tmo=%0d) expected 32", xfers, tmo); end
        checks++; if (seg_words[2] !== exp_info_word(2, 64'h44, 16'h0600, 16'h0300)) begin errors++;
            $display("FAIL ovf_snapshot: got %h expected %h", seg_words[2], exp_info_word(2, 64'h44, 16'h0600, 16'h0300)); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (o_busy !== 1'b0 || o_info_flag !== 1'b0) begin errors++;
            $display("FAIL ovf_no_requeue: got busy=%b flag=%b expected 0/0", o_busy, o_info_flag); end
    endtask

    task automatic test_reset_mid;
        set_info(64'h55, 16'h0500, 16'h0400);
        pulse_start(1'b1, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        checks++; if (o_info_flag !== 1'b1 || ov_cmd_data !== exp_info_word(5, 64'h55, 16'h0500, 16'h0400)) begin errors++;
            $display("FAIL rstmid_word5: got flag=%b data=%h expected 1/%h", o_info_flag, ov_cmd_data,
                     exp_info_word(5, 64'h55, 16'h0500, 16'h0400)); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (o_info_flag !== 1'b0 || o_statis_flag !== 1'b0 || ov_dval !== 2'b00) begin errors++;
            $display("FAIL rstmid_async: got flags=%b%b dval=%b expected 00/00", o_info_flag, o_statis_flag, ov_dval); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", o_busy); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (o_info_flag !== 1'b0 || o_busy !== 1'b0 || ov_cmd_data !== 64'h0) begin errors++;
            $display("FAIL rstmid_no_resume: got flag=%b busy=%b data=%h expected 0/0/0", o_info_flag, o_busy, ov_cmd_data); end
    endtask

    initial begin
        reset = 1'b1;
        i_info_start = 1'b0; i_statis_start = 1'b0; i_ready = 1'b1;
        set_info(64'h0, 16'h0, 16'h0);
        iv_expect_payload_size = 32'h0; iv_valid_payload_size = 32'h0; iv_status_statis = 16'h0;
        test_reset();
        test_info();
        test_statis();
        test_ready_toggle();
        test_simultaneous();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
